// File: rtl/pc_ras_pkg.sv
// ============================================================================
// Module   : pc_ras_pkg
// Brief    : Next-PC operation encodings shared by the pc_ras block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_ras_pkg;

    localparam int PC_OP_W = 3;

    localparam logic [PC_OP_W-1:0] PC_INC  = 3'd0;
    localparam logic [PC_OP_W-1:0] PC_ABS  = 3'd1;
    localparam logic [PC_OP_W-1:0] PC_REL  = 3'd2;
    localparam logic [PC_OP_W-1:0] PC_CALL = 3'd3;
    localparam logic [PC_OP_W-1:0] PC_RET  = 3'd4;
    localparam logic [PC_OP_W-1:0] PC_HOLD = 3'd5;

endpackage

`default_nettype wire

// File: rtl/ras_stack.sv
// ============================================================================
// Module   : ras_stack
// Brief    : Circular return-address stack; a push when full drops the oldest.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ras_stack #(
    parameter int AW    = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_f,
    input  logic                     push,
    input  logic                     pop,
    input  logic [AW-1:0]            push_data,
    output logic [AW-1:0]            top_data,
    output logic [$clog2(DEPTH):0]   cnt,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    logic [AW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_top;
    logic [CW-1:0] r_cnt;
    logic [PW-1:0] w_wr_ptr;

    // Slot above the top is also the oldest entry when full, so a full push
    // overwrites it naturally.
    assign w_wr_ptr = r_top + PW'(1);

    always_ff @(posedge clk) begin
        if (!rst_f) begin
            r_top <= '0;
            r_cnt <= '0;
        end else if (push) begin
            r_top <= w_wr_ptr;
            if (r_cnt != C_DEPTH) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end else if (pop && (r_cnt != '0)) begin
            r_top <= r_top - PW'(1);
            r_cnt <= r_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[w_wr_ptr] <= push_data;
        end
    end

    assign top_data = r_mem[r_top];
    assign cnt      = r_cnt;
    assign full     = (r_cnt == C_DEPTH);
    assign empty    = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/pc_ras.sv
// ============================================================================
// Module   : pc_ras
// Brief    : Program counter with abs/rel branch, hold and CALL/RET stack.
//            PC_RAS_TRAP_EN: stack faults jump to TRAP_VEC instead.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_ras
    import pc_ras_pkg::*;
#(
    parameter int              AW        = 16,
    parameter int              OW        = 8,
    parameter int              DEPTH     = 4,
    parameter logic [AW-1:0]   RESET_VEC = '0,
    parameter logic [AW-1:0]   TRAP_VEC  = 16'hFFF0
) (
    input  logic                     clk,
    input  logic                     rst_f,
    input  logic                     pc_write,
    input  logic [PC_OP_W-1:0]       pc_op,
    input  logic [AW-1:0]            br_addr,
    input  logic [OW-1:0]            br_off,
    input  logic                     flag_clr,
    output logic [AW-1:0]            pc_out,
    output logic [AW-1:0]            pc_inc,
    output logic [$clog2(DEPTH):0]   ras_cnt,
    output logic                     ras_empty,
    output logic                     ras_full,
    output logic                     ras_ovf,
    output logic                     ras_unf
);

    logic [AW-1:0] r_pc;
    logic          r_ovf;
    logic          r_unf;

    logic [AW-1:0] w_pc_inc;
    logic [AW-1:0] w_off_ext;
    logic [AW-1:0] w_pc_next;
    logic [AW-1:0] w_top;
    logic          w_push;
    logic          w_pop;
    logic          w_ovf_set;
    logic          w_unf_set;
    logic          w_full;
    logic          w_empty;

    assign w_pc_inc  = r_pc + AW'(1);
    assign w_off_ext = {{(AW-OW){br_off[OW-1]}}, br_off};

`ifndef PC_RAS_TRAP_EN
    logic w_unused_trap;
    assign w_unused_trap = ^TRAP_VEC;
`endif

    ras_stack #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_ras_stack (
        .clk       (clk),
        .rst_f     (rst_f),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_pc_inc),
        .top_data  (w_top),
        .cnt       (ras_cnt),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_comb begin
        w_pc_next = r_pc;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_ovf_set = 1'b0;
        w_unf_set = 1'b0;
        if (pc_write) begin
            case (pc_op)
                PC_INC: w_pc_next = w_pc_inc;
                PC_ABS: w_pc_next = br_addr;
                PC_REL: w_pc_next = w_pc_inc + w_off_ext;
                PC_CALL: begin
                    w_ovf_set = w_full;
`ifdef PC_RAS_TRAP_EN
                    if (w_full) begin
                        w_pc_next = TRAP_VEC;
                    end else begin
                        w_push    = 1'b1;
                        w_pc_next = br_addr;
                    end
`else
                    w_push    = 1'b1;
                    w_pc_next = br_addr;
`endif
                end
                PC_RET: begin
                    if (w_empty) begin
                        w_unf_set = 1'b1;
`ifdef PC_RAS_TRAP_EN
                        w_pc_next = TRAP_VEC;
`else
                        w_pc_next = w_pc_inc;
`endif
                    end else begin
                        w_pop     = 1'b1;
                        w_pc_next = w_top;
                    end
                end
                default: w_pc_next = r_pc;
            endcase
        end
    end

    // A fault in the same cycle as flag_clr leaves the flag set.
    always_ff @(posedge clk) begin
        if (!rst_f) begin
            r_pc  <= RESET_VEC;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_pc  <= w_pc_next;
            r_ovf <= w_ovf_set | (r_ovf & ~flag_clr);
            r_unf <= w_unf_set | (r_unf & ~flag_clr);
        end
    end

    assign pc_out    = r_pc;
    assign pc_inc    = w_pc_inc;
    assign ras_empty = w_empty;
    assign ras_full  = w_full;
    assign ras_ovf   = r_ovf;
    assign ras_unf   = r_unf;

endmodule

`default_nettype wire

// File: tb/tb_pc_ras.sv
// ============================================================================
// Module   : tb_pc_ras
// Brief    : Directed self-checking bench for pc_ras (default DEPTH=4, AW=16).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_ras;

    logic        clk;
    logic        rst_f;
    logic        pc_write;
    logic [2:0]  pc_op;
    logic [15:0] br_addr;
    logic [7:0]  br_off;
    logic        flag_clr;
    logic [15:0] pc_out;
    logic [15:0] pc_inc;
    logic [2:0]  ras_cnt;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_ovf;
    logic        ras_unf;

    int checks   = 0;
    int failures = 0;

    pc_ras u_dut (
        .clk       (clk),
        .rst_f     (rst_f),
        .pc_write  (pc_write),
        .pc_op     (pc_op),
        .br_addr   (br_addr),
        .br_off    (br_off),
        .flag_clr  (flag_clr),
        .pc_out    (pc_out),
        .pc_inc    (pc_inc),
        .ras_cnt   (ras_cnt),
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
        .ras_ovf   (ras_ovf),
        .ras_unf   (ras_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [2:0] op, input logic [15:0] addr,
                        input logic [7:0] off, input logic wr, input logic clr);
        pc_op    = op;
        br_addr  = addr;
        br_off   = off;
        pc_write = wr;
        flag_clr = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_f = 1'b0;
        pc_write = 1'b0; pc_op = 3'd0; br_addr = '0; br_off = '0; flag_clr = 1'b0;

        // Reset
        step(3'd0, 16'h0, 8'h0, 1'b0, 1'b0);
        chk("rst_pc", {16'h0, pc_out}, 32'h0000);
        chk("rst_cnt", {29'h0, ras_cnt}, 32'd0);
        chk("rst_empty", {31'h0, ras_empty}, 32'd1);
        chk("rst_full", {31'h0, ras_full}, 32'd0);
        chk("rst_flags", {30'h0, ras_ovf, ras_unf}, 32'd0);
        rst_f = 1'b1;

        // Increment
        step(3'd0, 16'h0, 8'h0, 1'b1, 1'b0);
        chk("inc1", {16'h0, pc_out}, 32'h0001);
        step(3'd0, 16'h0, 8'h0, 1'b1, 1'b0);
        chk("inc2", {16'h0, pc_out}, 32'h0002);
        step(3'd0, 16'h0, 8'h0, 1'b1, 1'b0);
        chk("inc3", {16'h0, pc_out}, 32'h0003);
        chk("inc3_pcinc", {16'h0, pc_inc}, 32'h0004);

        // Relative branch
        step(3'd1, 16'h0010, 8'h0, 1'b1, 1'b0);
        chk("abs", {16'h0, pc_out}, 32'h0010);
        step(3'd2, 16'h0, 8'hFC, 1'b1, 1'b0);
        chk("rel_neg", {16'h0, pc_out}, 32'h000D);
        step(3'd1, 16'h0010, 8'h0, 1'b1, 1'b0);
        step(3'd2, 16'h0, 8'h05, 1'b1, 1'b0);
        chk("rel_pos", {16'h0, pc_out}, 32'h0016);

        // Nested calls
        step(3'd1, 16'h0020, 8'h0, 1'b1, 1'b0);
        step(3'd3, 16'h0100, 8'h0, 1'b1, 1'b0);
        chk("call1_pc", {16'h0, pc_out}, 32'h0100);
        chk("call1_cnt", {29'h0, ras_cnt}, 32'd1);
        step(3'd3, 16'h0200, 8'h0, 1'b1, 1'b0);
        chk("call2_pc", {16'h0, pc_out}, 32'h0200);
        chk("call2_cnt", {29'h0, ras_cnt}, 32'd2);
        step(3'd4, 16'h0, 8'h0, 1'b1, 1'b0);
        chk("ret1_pc", {16'h0, pc_out}, 32'h0101);
        chk("ret1_cnt", {29'h0, ras_cnt}, 32'd1);
        step(3'd4, 16'h0, 8'h0, 1'b1, 1'b0);
        chk("ret2_pc", {16'h0, pc_out}, 32'h0021);
        chk("ret2_cnt", {29'h0, ras_cnt}, 32'd0);

        // Hold modes
        step(3'd3, 16'h0300, 8'h0, 1'b0, 1'b0);
        chk("nowr_call_pc", {16'h0, pc_out}, 32'h0021);
        chk("nowr_call_cnt", {29'h0, ras_cnt}, 32'd0);
        step(3'd4, 16'h0, 8'h0, 1'b0, 1'b0);
        chk("nowr_ret_unf", {31'h0, ras_unf}, 32'd0);
        step(3'd5, 16'h0300, 8'h0, 1'b1, 1'b0);
        chk("hold_pc", {16'h0, pc_out}, 32'h0021);
        step(3'd6, 16'h0300, 8'h0, 1'b1, 1'b0);
        chk("rsvd6_pc", {16'h0, pc_out}, 32'h0021);
        step(3'd7, 16'h0300, 8'h0, 1'b1, 1'b0);
        chk("rsvd7_pc", {16'h0, pc_out}, 32'h0021);

        // Fill the stack: pushes 0x0022, 0x1001, 0x2001, 0x3001
        step(3'd3, 16'h1000, 8'h0, 1'b1, 1'b0);
        step(3'd3, 16'h2000, 8'h0, 1'b1, 1'b0);
        step(3'd3, 16'h3000, 8'h0, 1'b1, 1'b0);
        step(3'd3, 16'h4000, 8'h0, 1'b1, 1'b0);
        chk("fill_cnt", {29'h0, ras_cnt}, 32'd4);
        chk("fill_full", {31'h0, ras_full}, 32'd1);
        chk("fill_ovf", {31'h0, ras_ovf}, 32'd0);
        step(3'd3, 16'h5000, 8'h0, 1'b1, 1'b0);
        chk("ovf_cnt", {29'h0, ras_cnt}, 32'd4);
        chk("ovf_flag", {31'h0, ras_ovf}, 32'd1);
`ifdef PC_RAS_TRAP_EN
        chk("ovf_pc", {16'h0, pc_out}, 32'hFFF0);
        step(3'd4, 16'h0, 8'h0, 1'b1, 1'b0);
        chk("pop1", {16'h0, pc_out}, 32'h3001);
        step(3'd4, 16'h0, 8'h0, 1'b1, 1'b0);
        chk("pop2", {16'h0, pc_out}, 32'h2001);
        step(3'd4, 16'h0, 8'h0, 1'b1, 1'b0);
        chk("pop3", {16'h0, pc_out}, 32'h1001);
        step(3'd4, 16'h0, 8'h0, 1'b1, 1'b0);
        chk("pop4", {16'h0, pc_out}, 32'h0022);
        step(3'd4, 16'h0, 8'h0, 1'b1, 1'b0);
        chk("unf_pc", {16'h0, pc_out}, 32'hFFF0);
`else
        chk("ovf_pc", {16'h0, pc_out}, 32'h5000);
        step(3'd4, 16'h0, 8'h0, 1'b1, 1'b0);
        chk("pop1", {16'h0, pc_out}, 32'h4001);
        step(3'd4, 16'h0, 8'h0, 1'b1, 1'b0);
        chk("pop2", {16'h0, pc_out}, 32'h3001);
        step(3'd4, 16'h0, 8'h0, 1'b1, 1'b0);
        chk("pop3", {16'h0, pc_out}, 32'h2001);
        step(3'd4, 16'h0, 8'h0, 1'b1, 1'b0);
        chk("pop4", {16'h0, pc_out}, 32'h1001);
        step(3'd4, 16'h0, 8'h0, 1'b1, 1'b0);
        chk("unf_pc", {16'h0, pc_out}, 32'h1002);
`endif
        chk("unf_cnt", {29'h0, ras_cnt}, 32'd0);
        chk("unf_flag", {31'h0, ras_unf}, 32'd1);
        chk("unf_ovf_sticky", {31'h0, ras_ovf}, 32'd1);

        // Flag clear, independent of pc_write
        step(3'd0, 16'h0, 8'h0, 1'b0, 1'b1);
        chk("clr_flags", {30'h0, ras_ovf, ras_unf}, 32'd0);
        step(3'd4, 16'h0, 8'h0, 1'b1, 1'b1);
        chk("clr_vs_set", {31'h0, ras_unf}, 32'd1);
        step(3'd5, 16'h0, 8'h0, 1'b1, 1'b1);
        chk("clr_again", {31'h0, ras_unf}, 32'd0);

        // Wrap-around
        step(3'd1, 16'hFFFF, 8'h0, 1'b1, 1'b0);
        chk("wrap_pcinc", {16'h0, pc_inc}, 32'h0000);
        step(3'd0, 16'h0, 8'h0, 1'b1, 1'b0);
        chk("wrap_pc", {16'h0, pc_out}, 32'h0000);
        step(3'd1, 16'hFFFE, 8'h0, 1'b1, 1'b0);
        step(3'd2, 16'h0, 8'h05, 1'b1, 1'b0);
        chk("rel_wrap", {16'h0, pc_out}, 32'h0004);

        // Reset during a CALL discards the stack
        step(3'd1, 16'h0040, 8'h0, 1'b1, 1'b0);
        step(3'd3, 16'h0500, 8'h0, 1'b1, 1'b0);
        chk("pre_rst_cnt", {29'h0, ras_cnt}, 32'd1);
        rst_f = 1'b0;
        step(3'd3, 16'h0600, 8'h0, 1'b1, 1'b0);
        chk("mid_rst_pc", {16'h0, pc_out}, 32'h0000);
        chk("mid_rst_cnt", {29'h0, ras_cnt}, 32'd0);
        rst_f = 1'b1;
        step(3'd4, 16'h0, 8'h0, 1'b1, 1'b0);
`ifdef PC_RAS_TRAP_EN
        chk("post_rst_ret", {16'h0, pc_out}, 32'hFFF0);
`else
        chk("post_rst_ret", {16'h0, pc_out}, 32'h0001);
`endif
        chk("post_rst_unf", {31'h0, ras_unf}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pc_ras.md
Name: pc_ras

Overview:
- Next-generation SISC program counter with parametrised address width.
- Adds relative/absolute branch selection, a hold mode and a hardware return-address stack (RAS) for CALL/RET.
- Sits between the control unit, which drives pc_write and pc_op, and instruction memory, which consumes pc_out.
- pc_inc feeds the branch-address logic and the RAS push path.

Parameters:
- AW, 16, address width in bits (pc_out, pc_inc, br_addr, RAS entries).
- OW, 8, relative-branch offset width; two's complement, sign-extended to AW.
- DEPTH, 4, number of RAS entries; must be a power of 2 and at least 2.
- RESET_VEC, 0, pc_out value after reset (AW bits).
- TRAP_VEC, 16'hFFF0, RAS fault target; used only with the optional feature.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_f  in  1  synchronous, active-low reset.
- pc_write  in  1  update enable; when low, pc_out and the RAS hold.
- pc_op  in  3  next-PC operation (encodings under Behaviour).
- br_addr  in  AW  absolute target for ABS and CALL.
- br_off  in  OW  signed offset for REL.
- flag_clr  in  1  clears the sticky ras_ovf/ras_unf flags.
- pc_out  out  AW  current PC, registered.
- pc_inc  out  AW  pc_out+1 modulo 2^AW, combinational.
- ras_cnt  out  clog2(DEPTH)+1  number of valid RAS entries.
- ras_empty  out  1  ras_cnt==0.
- ras_full  out  1  ras_cnt==DEPTH.
- ras_ovf  out  1  sticky: a CALL was issued while the RAS was full.
- ras_unf  out  1  sticky: a RET was issued while the RAS was empty.

Behaviour:
- Reset:
  - Sampled on the clk rising edge with rst_f==0; reset has priority over pc_write.
  - pc_out=RESET_VEC, ras_cnt=0, ras_ovf=0, ras_unf=0.
  - RAS entry contents are don't-care.
- pc_op encoding (all updates happen only when pc_write==1):
  - 0 INC: pc_out <= pc_inc.
  - 1 ABS: pc_out <= br_addr.
  - 2 REL: pc_out <= pc_inc + sext(br_off), modulo 2^AW.
  - 3 CALL: push pc_inc; pc_out <= br_addr.
  - 4 RET: pop top entry; pc_out <= popped value.
  - 5 HOLD: no change.
  - 6 and 7: reserved, treated as HOLD.
- Latency: one cycle. The new pc_out is visible the cycle after the pc_write edge; pc_inc follows combinationally.
- Wrap-around:
  - pc_out at all-ones with INC gives 0.
  - REL arithmetic wraps silently; no flag.
- CALL with the RAS full (default build):
  - Circular overwrite: the oldest entry is lost and the new entry becomes the top.
  - ras_cnt stays at DEPTH; ras_ovf is set; the branch is still taken.
- RET with the RAS empty (default build):
  - pc_out <= pc_inc; ras_cnt stays 0; ras_unf is set.
- pc_write==0: CALL/RET have no RAS effect and flags do not change.
- flag_clr:
  - Clears both sticky flags regardless of pc_write.
  - If flag_clr and a new fault occur in the same cycle, the set wins.
- Reset mid-sequence discards all RAS contents.

Optional Feature:
- Macro: PC_RAS_TRAP_EN.
- Defined:
  - CALL with the RAS full does not push; pc_out <= TRAP_VEC and ras_ovf is set.
  - RET with the RAS empty sets pc_out <= TRAP_VEC and ras_unf is set.
  - RAS contents and ras_cnt are unchanged in both cases.
- Undefined: overwrite/fall-through behaviour as described under Behaviour; TRAP_VEC is unused.

Decomposition:
- Package pc_ras_pkg holds:
  - pc_op localparams: PC_INC, PC_ABS, PC_REL, PC_CALL, PC_RET, PC_HOLD.
  - Op width constant (3).
- Sub-module ras_stack (parameters AW, DEPTH):
  - Inputs: push, pop, push_data.
  - Outputs: top_data, cnt, full, empty.
  - Circular-overwrite push when full; pop ignored when empty.
  - Trap gating of push/pop lives in pc_ras, not in ras_stack.

Test Plan:
- Reset and increment: rst_f=0 for 1 cycle, then INC with pc_write=1 for 3 cycles -> pc_out sequence 0, 1, 2, 3; pc_inc=4.
- Relative branch: pc_out=0x0010, REL with br_off=8'hFC -> pc_out=0x000D; with br_off=8'h05 -> pc_out=0x0016.
- Nested calls: CALL to 0x0100 from 0x0020, then CALL to 0x0200 from 0x0100, then RET, RET -> pc_out sequence 0x0100, 0x0200, 0x0101, 0x0021; ras_cnt 1, 2, 1, 0.
- Overflow (default build, DEPTH=4): 5 CALLs then 5 RETs -> ras_ovf=1 after the 5th CALL. First 4 RETs return the newest 4 addresses. The 5th RET gives pc_inc and sets ras_unf=1. flag_clr clears both flags.
- Trap build (PC_RAS_TRAP_EN defined): RET with the RAS empty -> pc_out=0xFFF0, ras_unf=1, ras_cnt=0. A 5th CALL -> pc_out=0xFFF0 and ras_cnt stays 4.
- Hold and wrap: pc_write=0 with op=CALL -> no change. pc_out=0xFFFF with INC -> 0x0000. rst_f=0 during a CALL -> pc_out=RESET_VEC, ras_cnt=0.
